// File: rtl/tree_node_rr_mux.sv
// N-to-1 packet concentrator: per-packet round-robin arbitration over child
// valid/ready streams into one registered upstream port tagged with the source id.
module tree_node_rr_mux #(
   parameter int unsigned NUM_CH = 15,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = $clog2(NUM_CH),
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_last,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [ID_W-1:0]          out_id,
   input  logic                     out_ready,
   output logic                     busy,
   output logic [CNT_W-1:0]         pkt_cnt
);

   typedef enum logic {ST_IDLE, ST_LOCK} state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     lock_q, lock_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic [ID_W-1:0]     out_id_q, out_id_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                can_load;
   logic [ID_W-1:0]     win;
   logic                win_vld;
   logic [ID_W-1:0]     gnt;
   logic                gnt_vld;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic                accept;

   assign can_load = !out_valid_q || out_ready;

   // Winner is the valid channel at the smallest circular distance past ptr.
   always_comb begin : arb_search
      int unsigned p;
      int unsigned d;
      int unsigned best;
      win     = '0;
      win_vld = 1'b0;
      best    = NUM_CH;
      d       = 0;
      p       = 32'(ptr_q);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         d = i + NUM_CH - 1 - p;
         if (d >= NUM_CH) d = d - NUM_CH;
         if (ch_valid[i] && (d < best)) begin
            best    = d;
            win     = ID_W'(i);
            win_vld = 1'b1;
         end
      end
   end

   assign gnt     = (state_q == ST_LOCK) ? lock_q : win;
   assign gnt_vld = (state_q == ST_LOCK) || win_vld;

   // Granted channel's beat and the one-hot ready vector.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      ch_ready  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ID_W'(i) == gnt) begin
            sel_valid   = ch_valid[i];
            sel_last    = ch_last[i];
            sel_data    = ch_data[i*DATA_W +: DATA_W];
            ch_ready[i] = can_load && gnt_vld;
         end
      end
   end

   assign accept = gnt_vld && can_load && sel_valid;

   // Next state, output register and packet counter.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_d      = lock_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_id_d    = out_id_q;
      cnt_d       = cnt_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         if (out_last_q) cnt_d = cnt_q + CNT_W'(1);
      end

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_last_d  = sel_last;
         out_id_d    = gnt;
         case (state_q)
            ST_IDLE: begin
               ptr_d = gnt;
               if (!sel_last) begin
                  state_d = ST_LOCK;
                  lock_d  = gnt;
               end
            end
            ST_LOCK: begin
               if (sel_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_LOCK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= ID_W'(NUM_CH - 1);
         lock_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_id_q    <= '0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_q      <= lock_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_id_q    <= out_id_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_id    = out_id_q;
   assign busy      = busy_q;
   assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_tree_node_rr_mux.sv
// Bench for tree_node_rr_mux: per-channel packet queues, a round-robin reference
// model and a scoreboard checked by an independent output monitor.
module tb_tree_node_rr_mux;

   localparam int NCH = 15;
   localparam int DW  = 32;
   localparam int IDW = 4;
   localparam int CW  = 16;

   typedef struct packed {
      logic [DW-1:0]  d;
      logic           l;
      logic [IDW-1:0] id;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NCH-1:0]    ch_valid, ch_last, ch_ready;
   logic [NCH*DW-1:0] ch_data;
   logic              out_valid, out_last, out_ready, busy;
   logic [DW-1:0]     out_data;
   logic [IDW-1:0]    out_id;
   logic [CW-1:0]     pkt_cnt;

   logic [4:0]        s_ch_valid, s_ch_last, s_ch_ready;
   logic [5*DW-1:0]   s_ch_data;
   logic              s_out_valid, s_out_last, s_out_ready, s_busy;
   logic [DW-1:0]     s_out_data;
   logic [2:0]        s_out_id;
   logic [1:0]        s_pkt_cnt;

   tree_node_rr_mux #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
      .out_ready(out_ready), .busy(busy), .pkt_cnt(pkt_cnt));

   tree_node_rr_mux #(.NUM_CH(5), .DATA_W(DW), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .ch_valid(s_ch_valid), .ch_data(s_ch_data), .ch_last(s_ch_last), .ch_ready(s_ch_ready),
      .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .out_id(s_out_id),
      .out_ready(s_out_ready), .busy(s_busy), .pkt_cnt(s_pkt_cnt));

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] bd [NCH][40];
   logic          bl [NCH][40];
   int            hd [NCH];
   int            ln [NCH];
   logic [NCH-1:0] drop;

   int          m_ptr;
   bit          m_lock;
   int          m_lock_ch;
   bit          m_occ;
   logic [CW-1:0] m_pkts;
   exp_t        sb[$];
   exp_t        log_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic clear_q();
      for (int c = 0; c < NCH; c++) begin hd[c] = 0; ln[c] = 0; end
   endtask

   task automatic push_beat(input int c, input logic [DW-1:0] d, input logic l);
      bd[c][ln[c]] = d;
      bl[c][ln[c]] = l;
      ln[c]++;
   endtask

   task automatic push_pkt(input int c, input int n);
      for (int k = 0; k < n; k++) push_beat(c, DW'($urandom), (k == n - 1));
   endtask

   function automatic bit pending();
      bit p = m_occ;
      for (int c = 0; c < NCH; c++) if (hd[c] < ln[c]) p = 1'b1;
      return p;
   endfunction

   // One clock of stimulus plus the reference model's view of that clock.
   task automatic step(input logic rdy, input int pv);
      logic [NCH-1:0] cv, er;
      int  g;
      bit  has, can, acc;
      @(posedge clk); #1;
      out_ready = rdy;
      for (int c = 0; c < NCH; c++) begin
         cv[c] = (hd[c] < ln[c]) && !drop[c] && (int'($urandom_range(99)) < pv);
         ch_valid[c] = cv[c];
         ch_data[c*DW +: DW] = (hd[c] < ln[c]) ? bd[c][hd[c]] : '0;
         ch_last[c] = (hd[c] < ln[c]) ? bl[c][hd[c]] : 1'b0;
      end
      @(negedge clk);
      can = !m_occ || rdy;
      has = 1'b0;
      g   = 0;
      if (m_lock) begin
         g = m_lock_ch; has = 1'b1;
      end else begin
         for (int k = 1; k <= NCH; k++) begin
            int cc = (m_ptr + k) % NCH;
            if (!has && cv[cc]) begin g = cc; has = 1'b1; end
         end
      end
      er = (can && has) ? (NCH'(1) << g) : '0;
      chk("ch_ready", 64'(ch_ready), 64'(er));
      chk("busy", 64'(busy), 64'(m_lock));
      chk("out_valid", 64'(out_valid), 64'(m_occ));
      acc = can && has && cv[g];
      if (acc) begin
         sb.push_back('{d: bd[g][hd[g]], l: bl[g][hd[g]], id: IDW'(g)});
         if (!m_lock) begin
            m_ptr = g;
            if (!bl[g][hd[g]]) begin m_lock = 1'b1; m_lock_ch = g; end
         end else if (bl[g][hd[g]]) begin
            m_lock = 1'b0;
         end
         hd[g]++;
      end
      m_occ = acc || (m_occ && !rdy);
   endtask

   task automatic drain(input int pr, input int pv, input int max_cyc);
      int n = 0;
      while (pending() && n < max_cyc) begin
         step(int'($urandom_range(99)) < pr, pv);
         n++;
      end
      if (pending()) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: still pending after %0d cycles, want empty", n);
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic chk_ids(input string nm, input int e[$]);
      chk({nm, "_len"}, 64'(log_q.size()), 64'(e.size()));
      for (int i = 0; i < e.size() && i < log_q.size(); i++)
         chk(nm, 64'(log_q[i].id), 64'(e[i]));
   endtask

   // Monitor: pops the scoreboard on every upstream handshake, checks holds.
   bit            hold_v = 1'b0;
   logic [DW-1:0] hold_d;
   logic          hold_l;
   logic [IDW-1:0] hold_id;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(out_data), 64'(hold_d));
            chk("hold_id", 64'(out_id), 64'(hold_id));
            chk("hold_last", 64'(out_last), 64'(hold_l));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sb_empty: got beat id %0d, want no beat", out_id);
            end else begin
               e = sb.pop_front();
               chk("out_data", 64'(out_data), 64'(e.d));
               chk("out_id", 64'(out_id), 64'(e.id));
               chk("out_last", 64'(out_last), 64'(e.l));
               chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
               log_q.push_back(e);
               if (e.l) m_pkts = m_pkts + CW'(1);
            end
         end
         hold_v  = out_valid && !out_ready;
         hold_d  = out_data;
         hold_l  = out_last;
         hold_id = out_id;
      end
   end

   initial begin
      int eq[$];
      ch_valid = '0; ch_last = '0; ch_data = '0; out_ready = 1'b1;
      s_ch_valid = '0; s_ch_last = '0; s_ch_data = '0; s_out_ready = 1'b1;
      drop = '0;
      m_ptr = NCH - 1; m_lock = 1'b0; m_lock_ch = 0; m_occ = 1'b0; m_pkts = '0;
      clear_q();

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_out_id", 64'(out_id), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
      chk("rst_ch_ready", 64'(ch_ready), 64'(0));
      chk("rst_s_pkt_cnt", 64'(s_pkt_cnt), 64'(0));
      rst_n = 1'b1;

      // All channels single-beat, full throughput.
      log_q.delete();
      for (int c = 0; c < NCH; c++) push_pkt(c, 1);
      push_pkt(0, 1);
      for (int i = 0; i < 16; i++) step(1'b1, 100);
      drain(100, 100, 20);
      eq.delete();
      for (int i = 0; i < NCH; i++) eq.push_back(i);
      eq.push_back(0);
      chk_ids("t1_ids", eq);
      chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(16));

      // Channel 3 packet locks the port against channel 4.
      clear_q(); log_q.delete();
      push_pkt(3, 4); push_pkt(4, 1);
      drain(100, 100, 30);
      eq = '{3, 3, 3, 3, 4};
      chk_ids("t2_ids", eq);

      // Backpressure with a pending 0xDEADBEEF beat.
      clear_q(); log_q.delete();
      push_beat(1, 32'hDEADBEEF, 1'b1); push_beat(2, 32'h12345678, 1'b1);
      step(1'b1, 100);
      repeat (5) step(1'b0, 100);
      drain(100, 100, 20);
      chk("t3_len", 64'(log_q.size()), 64'(2));
      if (log_q.size() == 2) begin
         chk("t3_first", 64'(log_q[0].d), 64'(32'hDEADBEEF));
         chk("t3_second", 64'(log_q[1].d), 64'(32'h12345678));
      end

      // Locked channel 7 stalls three cycles while channel 8 waits.
      clear_q(); log_q.delete();
      push_pkt(7, 5); push_pkt(8, 1);
      repeat (2) step(1'b1, 100);
      drop[7] = 1'b1;
      repeat (3) step(1'b1, 100);
      drop = '0;
      drain(100, 100, 30);
      eq = '{7, 7, 7, 7, 7, 8};
      chk_ids("t4_ids", eq);

      // Reset in the middle of a five-beat packet.
      clear_q(); log_q.delete();
      push_pkt(5, 5);
      repeat (3) step(1'b1, 100);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_out_valid", 64'(out_valid), 64'(0));
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(0));
      sb.delete(); clear_q(); log_q.delete();
      m_ptr = NCH - 1; m_lock = 1'b0; m_occ = 1'b0; m_pkts = '0;
      ch_valid = '0; ch_last = '0;
      @(negedge clk);
      rst_n = 1'b1;
      push_beat(9, DW'($urandom), 1'b1); push_beat(0, DW'($urandom), 1'b1);
      drain(100, 100, 20);
      eq = '{0, 9};
      chk_ids("t5_ids", eq);

      // Randomized packets with random bubbles and backpressure.
      clear_q(); log_q.delete();
      for (int c = 0; c < NCH; c++)
         for (int p = 0; p < 6; p++) push_pkt(c, 1 + int'($urandom_range(3)));
      drain(70, 80, 4000);
      chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
      chk("rand_sb_empty", 64'(sb.size()), 64'(0));

      // Five-channel instance: pointer wraps 4 -> 0, 2-bit counter wraps.
      eq = '{4, 0, 4, 0, 4};
      for (int k = 0; k <= 5; k++) begin
         @(posedge clk); #1;
         if (k > 0) begin
            chk("s_valid", 64'(s_out_valid), 64'(1));
            chk("s_id", 64'(s_out_id), 64'(eq[k-1]));
            chk("s_data", 64'(s_out_data),
                64'((eq[k-1] == 4) ? 32'hB000_0000 + 32'(k-1) : 32'hA000_0000 + 32'(k-1)));
            chk("s_id_range", 64'(s_out_id < 3'd5), 64'(1));
         end
         if (k == 5) chk("s_pkt_cnt_wrap", 64'(s_pkt_cnt), 64'(0));
         if (k < 5) begin
            s_ch_valid = (k == 0) ? 5'b10000 : 5'b10001;
            s_ch_last  = '1;
            s_ch_data  = '0;
            s_ch_data[0*DW +: DW] = 32'hA000_0000 + 32'(k);
            s_ch_data[4*DW +: DW] = 32'hB000_0000 + 32'(k);
         end else begin
            s_ch_valid = '0;
         end
      end
      @(posedge clk); #1;
      chk("s_pkt_cnt", 64'(s_pkt_cnt), 64'(1));
      chk("s_drained", 64'(s_out_valid), 64'(0));

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
